fft_ctrl: RTL and testbench

Sequencing controller for the 32-point in-place radix-2 DIT FFT. Sits directly in front of the dual-port 16-bit sample RAM and drives both of its ports. It loads an input stream into the RAM in bit-reversed order, then walks 5 butterfly stages, feeding the external butterfly and writing its results back. Finally it streams the 32 results out in address order.

---
 rtl/fft_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_fft_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_ctrl.sv
// ---------------------------------------------------------------------------
// fft_ctrl
// Sequencing controller for an N-point (N = 2**ADDR_W) in-place radix-2 DIT
// FFT built around a dual-port sample RAM and an external butterfly.
//
// A frame runs through three phases:
//   LOAD   : input samples are written to port A in bit-reversed order.
//   READ/WRITE pairs : for every stage s and butterfly k the two operand
//            addresses are read, then the butterfly results are written
//            back to the same addresses on the following cycle.
//   UNLOAD : port A is swept 0..N-1 and the registered read data is
//            forwarded as the output stream.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   start                   begin a frame (only honoured while idle)
//   in_valid/in_data        input sample stream, in_ready high during LOAD
//   ram_addr_a/b, ram_wr_a/b, ram_wdata_a/b   RAM port A/B controls
//   ram_q_a                 RAM port A registered read data
//   bf_a_in, bf_b_in        butterfly results for the current operand pair
//   bf_en                   butterfly inputs valid (WRITE cycle)
//   tw_idx                  twiddle index k of W_N^k
//   out_valid/out_data      result stream in natural order
//   busy                    controller not idle
//   done                    pulse with the last out_valid of a frame
// ---------------------------------------------------------------------------
module fft_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] ram_addr_a,
    output logic [ADDR_W-1:0] ram_addr_b,
    output logic              ram_wr_a,
    output logic              ram_wr_b,
    output logic [DATA_W-1:0] ram_wdata_a,
    output logic [DATA_W-1:0] ram_wdata_b,
    input  logic [DATA_W-1:0] ram_q_a,
    input  logic [DATA_W-1:0] bf_a_in,
    input  logic [DATA_W-1:0] bf_b_in,
    output logic              bf_en,
    output logic [ADDR_W-2:0] tw_idx,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done
);

    localparam int SW = (ADDR_W > 1) ? $clog2(ADDR_W) : 1;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_READ   = 3'd2;
    localparam logic [2:0] ST_WRITE  = 3'd3;
    localparam logic [2:0] ST_UNLOAD = 3'd4;

    localparam logic [ADDR_W-1:0] CNT_LAST = '1;
    localparam logic [ADDR_W-1:0] ONE_A    = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-2:0] K_LAST   = '1;
    localparam logic [ADDR_W-2:0] ONE_K    = {{(ADDR_W-2){1'b0}}, 1'b1};
    localparam logic [SW-1:0]     S_LAST   = SW'(ADDR_W - 1);
    localparam logic [SW-1:0]     ONE_S    = {{(SW-1){1'b0}}, 1'b1};

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;     // LOAD sample count / UNLOAD address
    logic [ADDR_W-2:0] k_q, k_d;         // butterfly index within a stage
    logic [SW-1:0]     s_q, s_d;         // stage index
    logic              out_valid_q, done_q;

    function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] v);
        logic [ADDR_W-1:0] r;
        for (int i = 0; i < ADDR_W; i++) begin
            r[i] = v[ADDR_W-1-i];
        end
        return r;
    endfunction

    // Butterfly operand addresses and twiddle index for (s_q, k_q).
    logic [ADDR_W-1:0] half, pos, grp, bf_addr_a, bf_addr_b, tw_full;
    logic [SW-1:0]     tw_sh;

    always_comb begin
        half      = ONE_A << s_q;
        pos       = {1'b0, k_q} & (half - ONE_A);
        grp       = {1'b0, k_q} >> s_q;
        bf_addr_a = ((grp << s_q) << 1) | pos;
        // addr_a always has the 'half' bit clear, so OR is the same as add.
        bf_addr_b = bf_addr_a | half;
        tw_sh     = S_LAST - s_q;
        // pos < 2**s, so after the shift the value fits in ADDR_W-1 bits.
        tw_full   = pos << tw_sh;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        k_d     = k_q;
        s_d     = s_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                end
            end
            ST_LOAD: begin
                if (in_valid) begin
                    cnt_d = cnt_q + ONE_A;
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_READ;
                        cnt_d   = '0;
                        k_d     = '0;
                        s_d     = '0;
                    end
                end
            end
            ST_READ: begin
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                state_d = ST_READ;
                if (k_q == K_LAST) begin
                    k_d = '0;
                    if (s_q == S_LAST) begin
                        state_d = ST_UNLOAD;
                        s_d     = '0;
                        cnt_d   = '0;
                    end else begin
                        s_d = s_q + ONE_S;
                    end
                end else begin
                    k_d = k_q + ONE_K;
                end
            end
            ST_UNLOAD: begin
                cnt_d = cnt_q + ONE_A;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            k_q         <= '0;
            s_q         <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            k_q         <= k_d;
            s_q         <= s_d;
            // RAM read data appears one cycle after the UNLOAD address.
            out_valid_q <= (state_q == ST_UNLOAD);
            done_q      <= (state_q == ST_UNLOAD) && (cnt_q == CNT_LAST);
        end
    end

    // Output decode: everything is forced to zero outside its active cycles.
    always_comb begin
        ram_addr_a  = '0;
        ram_addr_b  = '0;
        ram_wr_a    = 1'b0;
        ram_wr_b    = 1'b0;
        ram_wdata_a = '0;
        ram_wdata_b = '0;
        bf_en       = 1'b0;
        tw_idx      = '0;
        case (state_q)
            ST_LOAD: begin
                if (in_valid) begin
                    ram_wr_a    = 1'b1;
                    ram_addr_a  = bitrev(cnt_q);
                    ram_wdata_a = in_data;
                end
            end
            ST_READ: begin
                ram_addr_a = bf_addr_a;
                ram_addr_b = bf_addr_b;
                tw_idx     = tw_full[ADDR_W-2:0];
            end
            ST_WRITE: begin
                ram_addr_a  = bf_addr_a;
                ram_addr_b  = bf_addr_b;
                ram_wr_a    = 1'b1;
                ram_wr_b    = 1'b1;
                ram_wdata_a = bf_a_in;
                ram_wdata_b = bf_b_in;
                bf_en       = 1'b1;
                tw_idx      = tw_full[ADDR_W-2:0];
            end
            ST_UNLOAD: begin
                ram_addr_a = cnt_q;
            end
            default: begin
            end
        endcase
    end

    assign in_ready  = (state_q == ST_LOAD);
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = out_valid_q;
    assign done      = done_q;
    assign out_data  = out_valid_q ? ram_q_a : '0;

endmodule

// File: tb/tb_fft_ctrl.sv
module tb_fft_ctrl;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 5;
    localparam int N      = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_ready;
    logic [ADDR_W-1:0] ram_addr_a, ram_addr_b;
    logic              ram_wr_a, ram_wr_b;
    logic [DATA_W-1:0] ram_wdata_a, ram_wdata_b;
    logic [DATA_W-1:0] q_a = '0;
    logic [DATA_W-1:0] q_b = '0;
    logic              bf_en;
    logic [ADDR_W-2:0] tw_idx;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              busy, done;

    fft_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .ram_addr_a(ram_addr_a), .ram_addr_b(ram_addr_b),
        .ram_wr_a(ram_wr_a), .ram_wr_b(ram_wr_b),
        .ram_wdata_a(ram_wdata_a), .ram_wdata_b(ram_wdata_b),
        .ram_q_a(q_a), .bf_a_in(q_a), .bf_b_in(q_b),
        .bf_en(bf_en), .tw_idx(tw_idx),
        .out_valid(out_valid), .out_data(out_data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Dual-port RAM with registered reads; butterfly is a pass-through.
    logic [DATA_W-1:0] mem [N];
    always @(posedge clk) begin
        q_a <= mem[ram_addr_a];
        q_b <= mem[ram_addr_b];
        if (ram_wr_a) mem[ram_addr_a] <= ram_wdata_a;
        if (ram_wr_b) mem[ram_addr_b] <= ram_wdata_b;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int t0 = 0;
    int frm = 0;

    // Per-frame event log, sampled on the falling edge.
    int ld_cnt [4] = '{default: 0};
    int ld_addr[4][N];
    int ld_data[4][N];
    int ir_seen[4] = '{default: 0};
    int ir_drop[4] = '{default: 0};
    int bf_cnt [4] = '{default: 0};
    int both_cnt[4] = '{default: 0};
    int bfa[4][80];
    int bfb[4][80];
    int bft[4][80];
    int out_cnt[4] = '{default: 0};
    int first_out[4] = '{default: 0};
    int out_d[4][N];
    int done_cnt[4] = '{default: 0};
    int done_rel[4] = '{default: 0};

    always @(negedge clk) begin
        if (rst_n) begin
            if (in_ready && ram_wr_a) begin
                if (ld_cnt[frm] < N) begin
                    ld_addr[frm][ld_cnt[frm]] <= int'(ram_addr_a);
                    ld_data[frm][ld_cnt[frm]] <= int'(ram_wdata_a);
                end
                ld_cnt[frm] <= ld_cnt[frm] + 1;
            end
            if (in_ready) ir_seen[frm] <= 1;
            if (busy && !in_ready && ir_seen[frm] == 1 && ir_drop[frm] == 0)
                ir_drop[frm] <= cyc - t0;
            if (bf_en) begin
                if (bf_cnt[frm] < 80) begin
                    bfa[frm][bf_cnt[frm]] <= int'(ram_addr_a);
                    bfb[frm][bf_cnt[frm]] <= int'(ram_addr_b);
                    bft[frm][bf_cnt[frm]] <= int'(tw_idx);
                end
                bf_cnt[frm] <= bf_cnt[frm] + 1;
                if (ram_wr_a && ram_wr_b) both_cnt[frm] <= both_cnt[frm] + 1;
            end
            if (out_valid) begin
                if (out_cnt[frm] == 0) first_out[frm] <= cyc - t0;
                if (out_cnt[frm] < N) out_d[frm][out_cnt[frm]] <= int'(out_data);
                out_cnt[frm] <= out_cnt[frm] + 1;
            end
            if (done) begin
                done_cnt[frm] <= done_cnt[frm] + 1;
                done_rel[frm] <= cyc - t0;
            end
        end
    end

    int nerr = 0;
    int nchk = 0;

    task automatic check(input string name, input longint act, input longint exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int brev5(input int v);
        int r = 0;
        for (int i = 0; i < 5; i++) if (((v >> i) & 1) != 0) r |= (1 << (4 - i));
        return r;
    endfunction

    // Drive one frame's inputs until the cycle 'upto' relative to t0.
    // Returns positioned 1 time unit after the edge that opens cycle 'upto'.
    int nsent = 0;
    task automatic run_cycles(input int upto, input bit toggle, input int base);
        int  rel;
        bit  acc;
        while (cyc - t0 < upto) begin
            rel      = cyc - t0;
            in_valid = toggle ? (rel % 2 == 1) : 1'b1;
            in_data  = DATA_W'(base + nsent);
            start    = (rel == 0) ||
                       (toggle && (rel == 100 || rel == 150 || rel == 240));
            acc      = in_ready && in_valid;
            @(posedge clk); #1;
            if (acc) nsent++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic check_frame(input int f, input int base, input int exp_ir,
                               input int exp_first, input int exp_done);
        check($sformatf("f%0d load writes", f), ld_cnt[f], 32);
        check($sformatf("f%0d in_ready drop", f), ir_drop[f], exp_ir);
        check($sformatf("f%0d bf_en cycles", f), bf_cnt[f], 80);
        check($sformatf("f%0d dual writes", f), both_cnt[f], 80);
        check($sformatf("f%0d out count", f), out_cnt[f], 32);
        check($sformatf("f%0d first out_valid", f), first_out[f], exp_first);
        check($sformatf("f%0d done cycle", f), done_rel[f], exp_done);
        check($sformatf("f%0d done count", f), done_cnt[f], 1);
        for (int m = 0; m < N; m++)
            check($sformatf("f%0d out[%0d]", f, m), out_d[f][m], base + brev5(m));
    endtask

    typedef struct {
        string name;
        int    kind;   // 0: load write of sample idx, 1: idx-th butterfly
        int    idx;
        int    exp_a;
        int    exp_b;
        int    exp_tw;
    } vec_t;

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{"load n0",   0, 0,  0,  0,  0};
        vecs[1]  = '{"load n1",   0, 1,  16, 0,  0};
        vecs[2]  = '{"load n2",   0, 2,  8,  0,  0};
        vecs[3]  = '{"load n3",   0, 3,  24, 0,  0};
        vecs[4]  = '{"load n6",   0, 6,  12, 0,  0};
        vecs[5]  = '{"load n31",  0, 31, 31, 0,  0};
        vecs[6]  = '{"bf s0k0",   1, 0,  0,  1,  0};
        vecs[7]  = '{"bf s0k7",   1, 7,  14, 15, 0};
        vecs[8]  = '{"bf s1k3",   1, 19, 5,  7,  8};
        vecs[9]  = '{"bf s2k5",   1, 37, 9,  13, 4};
        vecs[10] = '{"bf s3k10",  1, 58, 18, 26, 4};
        vecs[11] = '{"bf s4k15",  1, 79, 15, 31, 15};

        // Reset held with random inputs: every output must read zero.
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            start    = 1'($urandom_range(0, 1));
            in_data  = DATA_W'($urandom);
            @(negedge clk);
            check("reset ctrl", {busy, in_ready, ram_wr_a, ram_wr_b, out_valid, done, bf_en}, 0);
            check("reset buses", {ram_addr_a, ram_addr_b, ram_wdata_a, ram_wdata_b, tw_idx, out_data}, 0);
        end
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle after reset busy", busy, 0);
        check("idle after reset in_ready", in_ready, 0);

        // Frame 0: continuous input, x[n] = n + 100.
        frm = 0; t0 = cyc; nsent = 0;
        run_cycles(225, 1'b0, 100);
        @(negedge clk); #1;
        check("f0 idle at trailing done", busy, 0);
        check_frame(0, 100, 33, 194, 225);
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].kind == 0) begin
                check({vecs[i].name, " addr"}, ld_addr[0][vecs[i].idx], vecs[i].exp_a);
                check({vecs[i].name, " data"}, ld_data[0][vecs[i].idx], 100 + vecs[i].idx);
            end else begin
                check({vecs[i].name, " addr_a"}, bfa[0][vecs[i].idx], vecs[i].exp_a);
                check({vecs[i].name, " addr_b"}, bfb[0][vecs[i].idx], vecs[i].exp_b);
                check({vecs[i].name, " tw"}, bft[0][vecs[i].idx], vecs[i].exp_tw);
            end
        end

        // Frame 1: started in the trailing-done cycle; stalled input and
        // start pulses while busy.
        frm = 1; t0 = cyc; nsent = 0;
        run_cycles(256, 1'b1, 200);
        @(negedge clk); #1;
        check_frame(1, 200, 64, 225, 256);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("f1 no restart busy", busy, 0);
        end

        // Frame 2: reset asserted mid-compute.
        frm = 2; t0 = cyc; nsent = 0;
        run_cycles(100, 1'b0, 300);
        rst_n = 1'b0;
        #1;
        check("abort ctrl", {busy, in_ready, ram_wr_a, ram_wr_b, out_valid, done, bf_en}, 0);
        check("abort buses", {ram_addr_a, ram_addr_b, ram_wdata_a, ram_wdata_b, tw_idx, out_data}, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("after abort busy", busy, 0);
        check("abort frame no done", done_cnt[2], 0);

        // Frame 3: clean frame after the abort.
        frm = 3; t0 = cyc; nsent = 0;
        run_cycles(225, 1'b0, 400);
        @(negedge clk); #1;
        check_frame(3, 400, 33, 194, 225);
        check("f3 load n1 addr", ld_addr[3][1], 16);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
